timer_core: RTL and testbench
=============================

# timer_core

Timer execution stage of the pinmux timer subsystem, directly downstream of the timer register block. It consumes the global 1 µs divider value and the three per-timer configuration words with their write-update strobes. It generates the 1 µs and 1 ms system timebase pulses and runs three independent periodic up-counters. Each counter raises a one-cycle interrupt pulse toward the pinmux interrupt aggregator.

## Interface
- NTIMER, 3: number of timer channels (fixed at 3 for this release).
- mclk  input  1  system clock; single clock domain.
- h_reset_n  input  1  reset, asynchronous assert, active-low.
- cfg_pulse_1us  input  10  divider: pulse_1us period = cfg_pulse_1us+1 mclk cycles.
- cfg_timer_update  input  3  one-cycle strobe per timer: CPU wrote that timer's config.
- cfg_timer0/1/2  input  19 each  [15:0] limit, [17:16] timebase, [18] enable.
- pulse_1us  output  1  one-cycle pulse every 1 µs.
- pulse_1ms  output  1  one-cycle pulse every 1000 pulse_1us.
- timer_intr  output  3  one-cycle interrupt pulse per timer.

## Operation
- Reset: all counters 0; pulse_1us, pulse_1ms, timer_intr = 0.
- 1 µs divider: 10-bit counter, increments each mclk. When count >= cfg_pulse_1us, count clears and pulse_1us fires. The >= compare handles cfg lowered below the current count: the counter wraps on the next cycle. cfg_pulse_1us=0 gives pulse_1us high continuously.
- 1 ms divider: 10-bit counter of pulse_1us events, 0..999. On the pulse_1us where count==999, count clears and pulse_1ms fires.
- Timebase select [17:16]:
  - 00 = pulse_1us
  - 01 = pulse_1ms
  - 10 = every mclk
  - 11 = reserved, decodes as pulse_1us
  - The selected source is the per-timer "tick".
- Timer channel behaviour:
  - enable=0: counter held at 0, no interrupts.
  - enable=1: on each tick, if count==limit, count←0 and timer_intr fires; else count←count+1.
  - Period = (limit+1) ticks. limit=0 fires on every tick.
- cfg_timer_update[i]: counter i←0, and any interrupt that would have been generated that cycle is dropped.
  - Update and tick in the same cycle: update wins; the tick is lost, with no increment and no intr.
- Enable deasserted mid-count: counter clears next cycle; re-enable starts from 0.
- Limit lowered below the current count without an update strobe: counter counts up to 0xFFFF, wraps to 0, then matches. Software must always pair config writes with the update strobe, which the register stage guarantees.
- Counter widths: 16 bits, unsigned, modular.

## Timing
- All outputs registered.
- pulse_1us is asserted in the cycle after the divider compare cycle; its period is exactly cfg_pulse_1us+1 cycles.
- pulse_1ms is coincident with the pulse_1us it was derived from; its compare uses the registered pulse_1us.
- Tick-to-interrupt latency: 1 cycle. The tick and count==limit are sampled in cycle N; timer_intr is high in cycle N+1 only.
- Timebase 10 with limit=0 gives timer_intr high continuously, starting one cycle after enable.
- cfg_timer_update takes effect on the same clock edge: the counter reads 0 in the following cycle.
- Asynchronous reset mid-operation clears everything immediately. The first pulse_1us after release occurs cfg_pulse_1us+1 cycles later.

## Structure
- Shared package timer_pkg:
  - timebase encodings TB_1US=2'b00, TB_1MS=2'b01, TB_MCLK=2'b10.
  - field positions LIMIT_MSB=15, TB_LSB=16, EN_BIT=18.
  - MS_DIV=999.
- One sub-module, timer_unit: holds the 16-bit counter, timebase mux, update handling and intr register. It is instantiated three times.
- The 1 µs and 1 ms dividers live in timer_core itself.

## Test plan
- cfg_pulse_1us=49 → pulse_1us every 50 mclk, one cycle wide; pulse_1ms every 50 000 mclk.
- Timer0 = {en=1, tb=00, limit=3} with update strobe, cfg_pulse_1us=49 → timer_intr[0] every 200 mclk, one cycle wide; timers 1/2 silent.
- Timer1 = {en=1, tb=10, limit=0} → timer_intr[1] high every cycle starting one cycle after the update. Change limit to 9 with an update → pulse every 10 cycles, first pulse 10 cycles after the update.
- Timer2 at count 5 of limit 7 (tb=10): assert update coincident with a tick → count reads 0 next cycle, next intr exactly 8 cycles later, no spurious pulse.
- Drop enable on timer0 mid-count, re-enable 20 cycles later → no intr while disabled; first intr after the full limit+1 ticks.
- Assert h_reset_n low mid-period → all outputs 0 immediately. After release, pulse_1us resumes after cfg_pulse_1us+1 cycles; timers start from 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared encodings, widths and config-word layout for the timer execution stage.
package timer_pkg;

    localparam int unsigned NTIMER    = 3;
    localparam int unsigned CFG_W     = 19;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned DIV_W     = 10;
    localparam int unsigned LIMIT_MSB = 15;
    localparam int unsigned TB_LSB    = 16;
    localparam int unsigned EN_BIT    = 18;

    localparam logic [DIV_W-1:0] MS_DIV = DIV_W'(999);

    typedef enum logic [1:0] {
        TB_1US  = 2'b00,
        TB_1MS  = 2'b01,
        TB_MCLK = 2'b10,
        TB_RSVD = 2'b11
    } timebase_e;

    typedef struct packed {
        logic             en;
        timebase_e        tb;
        logic [CNT_W-1:0] limit;
    } timer_cfg_t;

    function automatic timer_cfg_t unpack_cfg(input logic [CFG_W-1:0] raw);
        timer_cfg_t c;
        c.en    = raw[EN_BIT];
        c.tb    = timebase_e'(raw[TB_LSB +: 2]);
        c.limit = raw[LIMIT_MSB:0];
        return c;
    endfunction

endpackage

// File: rtl/timer_unit.sv
// One periodic timer channel: timebase select, 16-bit counter, update handling, intr pulse.
module timer_unit
    import timer_pkg::*;
(
    input  logic       mclk,
    input  logic       h_reset_n,
    input  timer_cfg_t cfg,
    input  logic       update,
    input  logic       pulse_1us,
    input  logic       pulse_1ms,
    output logic       intr
);

    logic [CNT_W-1:0] count;
    logic             tick_c;

    always_comb begin
        tick_c = pulse_1us;
        case (cfg.tb)
            TB_1US:  tick_c = pulse_1us;
            TB_1MS:  tick_c = pulse_1ms;
            TB_MCLK: tick_c = 1'b1;
            default: tick_c = pulse_1us;
        endcase
    end

    // An update strobe outranks a coincident tick: the tick and its interrupt are lost.
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            count <= '0;
            intr  <= 1'b0;
        end else begin
            intr <= 1'b0;
            if (!cfg.en || update) begin
                count <= '0;
            end else if (tick_c) begin
                if (count == cfg.limit) begin
                    count <= '0;
                    intr  <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/timer_core.sv
// Timer execution stage: 1 us / 1 ms timebase dividers feeding three periodic timer units.
module timer_core
    import timer_pkg::*;
(
    input  logic              mclk,
    input  logic              h_reset_n,
    input  logic [DIV_W-1:0]  cfg_pulse_1us,
    input  logic [NTIMER-1:0] cfg_timer_update,
    input  logic [CFG_W-1:0]  cfg_timer0,
    input  logic [CFG_W-1:0]  cfg_timer1,
    input  logic [CFG_W-1:0]  cfg_timer2,
    output logic              pulse_1us,
    output logic              pulse_1ms,
    output logic [NTIMER-1:0] timer_intr
);

    logic [DIV_W-1:0] us_cnt;
    logic [DIV_W-1:0] ms_cnt;
    logic [DIV_W-1:0] ms_next_c;
    logic             us_hit_c;
    timer_cfg_t       cfg_arr [NTIMER];

    // >= so a lowered divider setting wraps on the next cycle instead of running to 1023.
    assign us_hit_c = (us_cnt >= cfg_pulse_1us);

    // Count of pulse_1us events including the one currently on the output.
    always_comb begin
        ms_next_c = ms_cnt;
        if (pulse_1us) begin
            ms_next_c = (ms_cnt == MS_DIV) ? '0 : ms_cnt + DIV_W'(1);
        end
    end

    // pulse_1ms is looked ahead one cycle so it lands on the same cycle as its pulse_1us.
    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            us_cnt    <= '0;
            ms_cnt    <= '0;
            pulse_1us <= 1'b0;
            pulse_1ms <= 1'b0;
        end else begin
            us_cnt    <= us_hit_c ? '0 : us_cnt + DIV_W'(1);
            pulse_1us <= us_hit_c;
            ms_cnt    <= ms_next_c;
            pulse_1ms <= us_hit_c && (ms_next_c == MS_DIV);
        end
    end

    assign cfg_arr[0] = unpack_cfg(cfg_timer0);
    assign cfg_arr[1] = unpack_cfg(cfg_timer1);
    assign cfg_arr[2] = unpack_cfg(cfg_timer2);

    for (genvar i = 0; i < NTIMER; i++) begin : g_unit
        timer_unit u_unit (
            .mclk      (mclk),
            .h_reset_n (h_reset_n),
            .cfg       (cfg_arr[i]),
            .update    (cfg_timer_update[i]),
            .pulse_1us (pulse_1us),
            .pulse_1ms (pulse_1ms),
            .intr      (timer_intr[i])
        );
    end

endmodule

// File: tb/tb_timer_core.sv
// Scoreboard bench for timer_core: arithmetic reference model predicts pulse cycles, monitor matches them.
module tb_timer_core;

    logic        mclk = 1'b0;
    logic        h_reset_n;
    logic [9:0]  cfg_pulse_1us;
    logic [2:0]  cfg_timer_update;
    logic [18:0] cfg_t [3];
    logic        pulse_1us;
    logic        pulse_1ms;
    logic [2:0]  timer_intr;

    timer_core dut (
        .mclk             (mclk),
        .h_reset_n        (h_reset_n),
        .cfg_pulse_1us    (cfg_pulse_1us),
        .cfg_timer_update (cfg_timer_update),
        .cfg_timer0       (cfg_t[0]),
        .cfg_timer1       (cfg_t[1]),
        .cfg_timer2       (cfg_t[2]),
        .pulse_1us        (pulse_1us),
        .pulse_1ms        (pulse_1ms),
        .timer_intr       (timer_intr)
    );

    always #5 mclk = ~mclk;

    int unsigned cyc = 0;
    always @(posedge mclk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // Expected pulse cycles: 0 pulse_1us, 1 pulse_1ms, 2..4 timer_intr[0..2]
    int unsigned exp_q [5][$];

    int unsigned rel_cyc = 0;
    bit          in_rst  = 1'b1;
    int unsigned ticks [3];

    function automatic string chan_name(int j);
        case (j)
            0: return "pulse_1us";
            1: return "pulse_1ms";
            2: return "timer_intr0";
            3: return "timer_intr1";
            default: return "timer_intr2";
        endcase
    endfunction

    // pulse_1us fires every (div+1) cycles counted from the reset-release cycle.
    function automatic bit us_at(int unsigned c);
        int unsigned per;
        per = 32'(cfg_pulse_1us) + 1;
        return (c > rel_cyc) && (((c - rel_cyc) % per) == 0);
    endfunction

    function automatic bit ms_at(int unsigned c);
        int unsigned per;
        per = 32'(cfg_pulse_1us) + 1;
        return us_at(c) && ((((c - rel_cyc) / per) % 1000) == 0);
    endfunction

    function automatic bit tick_at(int i, int unsigned c);
        case (cfg_t[i][17:16])
            2'b01:   return ms_at(c);
            2'b10:   return 1'b1;
            default: return us_at(c);
        endcase
    endfunction

    // Reference model: timer i fires one cycle after every (limit+1)-th accepted tick.
    always @(negedge mclk) begin
        if (!h_reset_n) begin
            in_rst = 1'b1;
            for (int i = 0; i < 3; i++) ticks[i] = 0;
        end else begin
            if (in_rst) begin
                rel_cyc = cyc;
                in_rst  = 1'b0;
            end
            if (us_at(cyc + 1)) exp_q[0].push_back(cyc + 1);
            if (ms_at(cyc + 1)) exp_q[1].push_back(cyc + 1);
            for (int i = 0; i < 3; i++) begin
                int unsigned period;
                period = 32'(cfg_t[i][15:0]) + 1;
                if (!cfg_t[i][18] || cfg_timer_update[i]) begin
                    ticks[i] = 0;
                end else if (tick_at(i, cyc)) begin
                    ticks[i] = ticks[i] + 1;
                    if ((ticks[i] % period) == 0) exp_q[2 + i].push_back(cyc + 1);
                end
            end
        end
    end

    // Monitor: every DUT pulse must match the head of its queue; missed heads are failures.
    always @(negedge mclk) begin
        logic [4:0] obs;
        obs = {timer_intr, pulse_1ms, pulse_1us};
        if (!h_reset_n) begin
            tests++;
            if (obs != 5'b0) begin
                fails++;
                $display("FAIL reset_outputs cycle %0d: got %b, expected 00000", cyc, obs);
            end
            for (int j = 0; j < 5; j++) exp_q[j].delete();
        end else begin
            for (int j = 0; j < 5; j++) begin
                while (exp_q[j].size() > 0 && exp_q[j][0] < cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL %s stale expectation at cycle %0d (now %0d): got 0, expected 1",
                             chan_name(j), exp_q[j][0], cyc);
                    void'(exp_q[j].pop_front());
                end
                if (exp_q[j].size() > 0 && exp_q[j][0] == cyc) begin
                    tests++;
                    void'(exp_q[j].pop_front());
                    if (!obs[j]) begin
                        fails++;
                        $display("FAIL %s missing pulse cycle %0d: got 0, expected 1", chan_name(j), cyc);
                    end
                end else if (obs[j]) begin
                    tests++;
                    fails++;
                    $display("FAIL %s spurious pulse cycle %0d: got 1, expected 0", chan_name(j), cyc);
                end
            end
        end
    end

    task automatic tick_n(int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic write_timer(int i, bit en, logic [1:0] tb, logic [15:0] lim);
        cfg_t[i]            = {en, tb, lim};
        cfg_timer_update[i] = 1'b1;
        tick_n(1);
        cfg_timer_update    = 3'b000;
    endtask

    task automatic do_reset(logic [9:0] div);
        @(posedge mclk);
        #3;
        h_reset_n = 1'b0;
        #1;
        tests++;
        if ({timer_intr, pulse_1ms, pulse_1us} != 5'b0) begin
            fails++;
            $display("FAIL async_reset_immediate: got %b, expected 00000", {timer_intr, pulse_1ms, pulse_1us});
        end
        cfg_pulse_1us = div;
        tick_n(3);
        h_reset_n = 1'b1;
    endtask

    initial begin
        int          ti;
        logic [1:0]  tb;
        int unsigned n;

        h_reset_n        = 1'b0;
        cfg_pulse_1us    = 10'd49;
        cfg_timer_update = 3'b000;
        cfg_t            = '{default: '0};
        tick_n(3);
        h_reset_n = 1'b1;
        tick_n(5);

        // Timer0 on 1 us timebase, limit 3: interrupt every 200 mclk
        write_timer(0, 1'b1, 2'b00, 16'd3);
        tick_n(1000);

        // Timer1 every mclk, limit 0 then limit 9
        write_timer(1, 1'b1, 2'b10, 16'd0);
        tick_n(30);
        write_timer(1, 1'b1, 2'b10, 16'd9);
        tick_n(60);

        // Timer2: second update lands on a tick while count is 5
        write_timer(2, 1'b1, 2'b10, 16'd7);
        tick_n(5);
        write_timer(2, 1'b1, 2'b10, 16'd7);
        tick_n(40);

        // Drop timer0 enable mid-count for 20 cycles
        tick_n(73);
        cfg_t[0][18] = 1'b0;
        tick_n(20);
        cfg_t[0][18] = 1'b1;
        tick_n(500);

        // Async reset while timer1 interrupt is continuously high, then fast divider for 1 ms checks
        write_timer(1, 1'b1, 2'b10, 16'd0);
        tick_n(7);
        do_reset(10'd1);
        tick_n(4100);

        for (int r = 0; r < 25; r++) begin
            if ($urandom_range(0, 7) == 0) do_reset(10'($urandom_range(0, 20)));
            ti = int'($urandom_range(0, 2));
            tb = 2'($urandom_range(0, 3));
            write_timer(ti, ($urandom_range(0, 4) != 0), tb, 16'($urandom_range(0, 12)));
            if ($urandom_range(0, 3) == 0) begin
                tick_n(int'($urandom_range(1, 30)));
                cfg_t[ti][18] = 1'b0;
                tick_n(int'($urandom_range(1, 10)));
                cfg_t[ti][18] = 1'b1;
            end
            n = $urandom_range(20, 400);
            tick_n(int'(n));
        end

        tick_n(5);
        for (int j = 0; j < 5; j++) begin
            n = 0;
            foreach (exp_q[j][k]) if (exp_q[j][k] < cyc) n++;
            tests++;
            if (n != 0) begin
                fails++;
                $display("FAIL %s leftover expectations: got %0d unmatched, expected 0", chan_name(j), n);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
